smachine_exec_unit: RTL
=======================

# smachine_exec_unit

Clocked, parametrised execute unit for the S-Machine CPU. It accepts one 16-bit instruction per `start` handshake and updates accumulator A, register B and the Z/N/C flags and PC. Loads and stores go through a request/acknowledge memory port, so memory may stall for any number of cycles. It sits between the fetch sequencer (drives `inst`/`start`, waits on `done`) and data memory.

## Interface
- `DATA_W`, 16: width of A, B, memory data; legal 16..64.
- `ADDR_W`, 8: width of PC and memory address; legal 4..8. Address is `inst[ADDR_W-1:0]`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inst`  in  16  instruction; sampled only on an accepted `start`.
- `start`  in  1  request to execute `inst`; accepted only in IDLE.
- `busy`  out  1  high from acceptance until `done` cycle inclusive.
- `done`  out  1  one-cycle pulse at completion.
- `illegal`  out  1  with `done`: opcode 0x3 or 0xF was executed.
- `pc`  out  ADDR_W  instruction count, wraps modulo 2^ADDR_W.
- `flag_z`, `flag_n`, `flag_c`  out  1 each  status flags.
- `reg_a`, `reg_b`  out  DATA_W  architectural registers (debug/observe).
- `mem_req`  out  1  memory request, held until acknowledged.
- `mem_we`  out  1  1 = store, 0 = load; stable while `mem_req`.
- `mem_addr`  out  ADDR_W  stable while `mem_req`.
- `mem_wdata`  out  DATA_W  store data; stable while `mem_req`.
- `mem_ack`  in  1  completes the request in the cycle it is high with `mem_req`.
- `mem_rdata`  in  DATA_W  load data; valid in the `mem_ack` cycle.

## Operation
- Opcode `inst[15:12]`. Register select `inst[11]` (0 = A, 1 = B). Immediate `imm = inst[7:0]`.
- Arithmetic is DATA_W+1 bits wide. C is the carry-out of the MSB.
- Flag update:
  - INC, ADD, SUB, OR, AND, XOR: Z = (result == 0), N = result MSB. C = carry for INC/ADD, borrow (A < B unsigned) for SUB, 0 for logic ops.
  - CMP: flags as SUB, but A is not written.
  - Z/N/C are unchanged by any opcode not listed here, unless noted.
- 0x0 LD:
  - `inst[10]`=1: immediate load. `inst[9]`=1 puts imm in the top 8 bits, else bottom 8; all other bits 0.
  - `inst[10]`=0: memory read into the selected register.
- 0x1 ST: memory write of the selected register.
- 0x2 INC: selected register += sign-extended imm. Flags are taken from the selected register.
- 0x4 ADD, 0x5 SUB, 0x6 OR, 0x7 AND, 0x8 XOR: A = A op B.
- 0x9 SHR: C = A[0]; A = A >> 1 (zero fill); Z and N are updated.
- 0xA MOV: B = A.
- 0xB EXCH: swap A and B.
- 0xC CMP: see flag update rules.
- 0xD SET: set each flag whose bit in `inst[10:8]` (Z, N, C) is 1. 0xE CLR: clear each flag whose bit in `inst[10:8]` is 1.
- 0x3, 0xF: no register or flag change; `illegal`=1 with `done`. PC still increments.
- FSM states:
  - IDLE: on `start`, latch `inst` and go to EXEC.
  - EXEC: register ops write results and go to DONE. Memory ops go to MEM.
  - MEM: `mem_req` high. On `mem_ack`, capture read data (loads) and go to DONE.
  - DONE: `done`=1, PC += 1, return to IDLE.

## Timing
- Reset values: A=0, B=0, PC=0, Z=N=C=0, `busy`=`done`=`illegal`=`mem_req`=`mem_we`=0, `mem_addr`=0, `mem_wdata`=0, state IDLE.
- `rst` overrides everything, including mid-MEM: `mem_req` drops at the next edge and the pending access is abandoned.
- Non-memory latency: `start` sampled at edge k; results visible after edge k+1; `done` high in the cycle after edge k+2.
- Memory latency: `mem_req` rises after edge k+1. `done` follows one cycle after the edge that samples `mem_ack`. Zero-wait ack gives 4 cycles start-to-done.
- `start` while `busy` is ignored; it is not queued.
- A new `start` may be accepted in the cycle after `done`.
- `mem_ack` without `mem_req` is ignored.

## Structure
- Package `smachine_pkg` holds:
  - opcode localparams;
  - the FSM state enum;
  - flag bit indices (Z=2, N=1, C=0).
- Sub-module `smachine_alu` is combinational: operands, opcode and imm in; result, Z/N/C and writes-A/writes-B strobes out. The FSM, registers and memory port stay in `smachine_exec_unit`.

## Test plan
- DATA_W=16. LD A imm 0xFF, LD B imm-high 0x01 (B=0x0100), ADD → A=0x01FF, Z=0, N=0, C=0. `done` exactly 2 edges after each `start`.
- A=0xFFFF, B=0x0001, ADD → A=0, Z=1, C=1. Then SUB with A=0, B=1 → A=0xFFFF, N=1, C=1.
- INC A by 0xFF (-1) from 0 → A=0xFFFF, N=1. Then SHR → A=0x7FFF, C=1. Then CMP with B=0x7FFF → Z=1, A unchanged.
- ST A to address 0x12 with `mem_ack` delayed 3 cycles: `mem_req`/`mem_we`/`mem_addr`/`mem_wdata` are stable throughout and `done` comes 1 cycle after ack. A following LD B from 0x12 returns the value.
- 256 instructions with ADDR_W=8 → PC wraps to 0. Opcode 0xF → `illegal`=1, no register change. A `start` pulse during `busy` → no extra `done`.
- Assert `rst` while `mem_req` is high → all outputs are at reset values after the next edge, and a late `mem_ack` has no effect.

Source files
------------

// File: rtl/smachine_pkg.sv
// Shared opcode encodings, FSM state type and flag bit positions for the S-Machine execute unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package smachine_pkg;

    localparam logic [3:0] OP_LD   = 4'h0;
    localparam logic [3:0] OP_ST   = 4'h1;
    localparam logic [3:0] OP_INC  = 4'h2;
    localparam logic [3:0] OP_ILL3 = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_MOV  = 4'hA;
    localparam logic [3:0] OP_EXCH = 4'hB;
    localparam logic [3:0] OP_CMP  = 4'hC;
    localparam logic [3:0] OP_SET  = 4'hD;
    localparam logic [3:0] OP_CLR  = 4'hE;
    localparam logic [3:0] OP_ILLF = 4'hF;

    // Flag vector layout {Z, N, C}; SET/CLR masks in inst[10:8] use the same order.
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MEM  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op == OP_ILL3) || (op == OP_ILLF);
    endfunction

endpackage

// File: rtl/smachine_if.sv
// Data-memory request/acknowledge port between the execute unit (master) and memory (slave).
// Latency: a request completes in the cycle mem_ack is high with mem_req.
// Backpressure: memory stalls by withholding mem_ack; master holds all request fields meanwhile.
interface smachine_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/smachine_alu.sv
// Combinational datapath for all register-only instructions: results, write strobes, next flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the FSM decides when outputs are committed.
module smachine_alu
    import smachine_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [15:0]       inst,
    input  logic [2:0]        flags_in,
    output logic [DATA_W-1:0] res_a,
    output logic [DATA_W-1:0] res_b,
    output logic              wr_a,
    output logic              wr_b,
    output logic [2:0]        flags_out
);
    logic [3:0]        op;
    logic              sel;
    logic [7:0]        imm;
    logic [DATA_W-1:0] sel_reg;
    logic [DATA_W-1:0] imm_sx;
    logic [DATA_W-1:0] imm_ld;

    assign op      = inst[15:12];
    assign sel     = inst[11];
    assign imm     = inst[7:0];
    assign sel_reg = sel ? b : a;
    assign imm_sx  = {{(DATA_W-8){imm[7]}}, imm};
    assign imm_ld  = inst[9] ? {imm, {(DATA_W-8){1'b0}}} : {{(DATA_W-8){1'b0}}, imm};

    // One extra bit on top of the result carries the carry/borrow (or the bit shifted out by SHR).
    always_comb begin
        logic [DATA_W:0] wide;
        logic            upd;
        wide      = '0;
        upd       = 1'b0;
        res_a     = a;
        res_b     = b;
        wr_a      = 1'b0;
        wr_b      = 1'b0;
        flags_out = flags_in;
        case (op)
            OP_LD: begin
                if (inst[10]) begin
                    res_a = imm_ld;
                    res_b = imm_ld;
                    wr_a  = !sel;
                    wr_b  = sel;
                end
            end
            OP_INC: begin
                wide  = {1'b0, sel_reg} + {1'b0, imm_sx};
                res_a = wide[DATA_W-1:0];
                res_b = wide[DATA_W-1:0];
                wr_a  = !sel;
                wr_b  = sel;
                upd   = 1'b1;
            end
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_SHR, OP_CMP: begin
                case (op)
                    OP_ADD:  wide = {1'b0, a} + {1'b0, b};
                    OP_OR:   wide = {1'b0, a | b};
                    OP_AND:  wide = {1'b0, a & b};
                    OP_XOR:  wide = {1'b0, a ^ b};
                    OP_SHR:  wide = {a[0], 1'b0, a[DATA_W-1:1]};
                    default: wide = {1'b0, a} - {1'b0, b};
                endcase
                res_a = wide[DATA_W-1:0];
                wr_a  = (op != OP_CMP);
                upd   = 1'b1;
            end
            OP_MOV: begin
                res_b = a;
                wr_b  = 1'b1;
            end
            OP_EXCH: begin
                res_a = b;
                res_b = a;
                wr_a  = 1'b1;
                wr_b  = 1'b1;
            end
            OP_SET:  flags_out = flags_in | inst[10:8];
            OP_CLR:  flags_out = flags_in & ~inst[10:8];
            default: ;
        endcase
        if (upd) begin
            flags_out[FLAG_Z] = (wide[DATA_W-1:0] == '0);
            flags_out[FLAG_N] = wide[DATA_W-1];
            flags_out[FLAG_C] = wide[DATA_W];
        end
    end
endmodule

// File: rtl/smachine_exec_unit.sv
// S-Machine execute unit: one instruction per start handshake, updates A/B/flags/PC.
// Latency: 2 edges after acceptance to done for register ops; 3 + memory wait states for LD/ST.
// Backpressure: start ignored while busy (not queued); memory stalls via mem_ack with request held.
module smachine_exec_unit
    import smachine_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       inst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic [ADDR_W-1:0] pc,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    smachine_if.master        mem
);
    state_t            state;
    logic [15:0]       inst_q;
    logic [2:0]        flags;
    logic [3:0]        op_q;
    logic              sel_q;
    logic              mem_op;
    logic [DATA_W-1:0] alu_res_a;
    logic [DATA_W-1:0] alu_res_b;
    logic              alu_wr_a;
    logic              alu_wr_b;
    logic [2:0]        alu_flags;

    assign op_q   = inst_q[15:12];
    assign sel_q  = inst_q[11];
    assign mem_op = (op_q == OP_ST) || ((op_q == OP_LD) && !inst_q[10]);

    assign flag_z = flags[FLAG_Z];
    assign flag_n = flags[FLAG_N];
    assign flag_c = flags[FLAG_C];

    smachine_alu #(.DATA_W(DATA_W)) u_alu (
        .a         (reg_a),
        .b         (reg_b),
        .inst      (inst_q),
        .flags_in  (flags),
        .res_a     (alu_res_a),
        .res_b     (alu_res_b),
        .wr_a      (alu_wr_a),
        .wr_b      (alu_wr_b),
        .flags_out (alu_flags)
    );

    // Control FSM plus all architectural state and the memory request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            inst_q        <= '0;
            reg_a         <= '0;
            reg_b         <= '0;
            flags         <= '0;
            pc            <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            illegal       <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                // busy is still high during the done cycle, which blocks a start there.
                S_IDLE: begin
                    busy <= 1'b0;
                    if (start && !busy) begin
                        inst_q <= inst;
                        busy   <= 1'b1;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (mem_op) begin
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= (op_q == OP_ST);
                        mem.mem_addr  <= inst_q[ADDR_W-1:0];
                        mem.mem_wdata <= sel_q ? reg_b : reg_a;
                        state         <= S_MEM;
                    end else begin
                        if (alu_wr_a) reg_a <= alu_res_a;
                        if (alu_wr_b) reg_b <= alu_res_b;
                        flags <= alu_flags;
                        state <= S_DONE;
                    end
                end
                S_MEM: begin
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        if (!mem.mem_we) begin
                            if (sel_q) reg_b <= mem.mem_rdata;
                            else       reg_a <= mem.mem_rdata;
                        end
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    illegal <= is_illegal_op(op_q);
                    pc      <= pc + ADDR_W'(1);
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
